// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline stage: decode-to-execute register with valid/ready
// handshake, optional skid buffer, flush and bubble-safe writeback.
module id_ex_pipe_stage #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] aluA_in,
  input  logic [DATA_W-1:0] aluB_in,
  input  logic [ADDR_W-1:0] gp_rdata1_address_in,
  input  logic [ADDR_W-1:0] gp_rdata2_address_in,
  input  logic [CTRL_W-1:0] alu_ctrl_in,
  input  logic              gp_reg_wb_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] aluA_out,
  output logic [DATA_W-1:0] aluB_out,
  output logic [ADDR_W-1:0] gp_rdata1_address_out,
  output logic [ADDR_W-1:0] gp_rdata2_address_out,
  output logic [CTRL_W-1:0] alu_ctrl_out,
  output logic              gp_reg_wb_out,
  output logic [1:0]        occupancy
);

  localparam int PW = 2*DATA_W + 2*ADDR_W + CTRL_W + 1;

  logic          m_vld_q, m_vld_d;
  logic          s_vld_q, s_vld_d;
  logic [PW-1:0] m_dat_q, m_dat_d;
  logic [PW-1:0] s_dat_q, s_dat_d;
  logic [PW-1:0] in_dat;
  logic          accept;
  logic          m_load;
  logic          m_wb;

  assign in_dat = {aluA_in, aluB_in,
                   gp_rdata1_address_in,
                   gp_rdata2_address_in,
                   alu_ctrl_in, gp_reg_wb_in};

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ~s_vld_q;
    end else begin : g_noskid
      assign in_ready = ~m_vld_q | out_ready;
    end
  endgenerate

  assign accept = in_valid & in_ready;
  assign m_load = ~m_vld_q | out_ready;

  // Next-state: flush squashes; otherwise refill M from S, then input.
  always_comb begin
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    m_dat_d = m_dat_q;
    s_dat_d = s_dat_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else begin
      if (m_load) begin
        if (s_vld_q) begin
          m_vld_d = 1'b1;
          m_dat_d = s_dat_q;
          s_vld_d = 1'b0;
        end else if (accept) begin
          m_vld_d = 1'b1;
          m_dat_d = in_dat;
        end else begin
          m_vld_d = 1'b0;
        end
      end
      if ((SKID != 0) && accept && !m_load) begin
        s_vld_d = 1'b1;
        s_dat_d = in_dat;
      end
    end
  end

  // State registers; reset drops any in-flight entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_dat_q <= '0;
      s_dat_q <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_dat_q <= m_dat_d;
      s_dat_q <= s_dat_d;
    end
  end

  assign {aluA_out, aluB_out,
          gp_rdata1_address_out,
          gp_rdata2_address_out,
          alu_ctrl_out, m_wb} = m_dat_q;

  assign out_valid     = m_vld_q;
  assign gp_reg_wb_out = m_vld_q & m_wb;
  assign occupancy     = {1'b0, m_vld_q} + {1'b0, s_vld_q};

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed bench for id_ex_pipe_stage: skid, no-skid and wide
// instances driven with hand-computed expected values.
module tb_id_ex_pipe_stage;

  logic clk;
  logic reset;

  int checks;
  int failures;

  // SKID=1 default instance
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [9:0]  aA, aB, oA, oB;
  logic [2:0]  r1, r2, o1, o2, ctl, octl;
  logic        wb, owb;
  logic [1:0]  occ;

  // SKID=0 instance
  logic        z_flush, z_iv, z_ir, z_ov, z_or;
  logic [9:0]  z_aA, z_aB, z_oA, z_oB;
  logic [2:0]  z_r1, z_r2, z_o1, z_o2, z_ctl, z_octl;
  logic        z_wb, z_owb;
  logic [1:0]  z_occ;

  // wide instance
  logic        w_flush, w_iv, w_ir, w_ov, w_or;
  logic [15:0] w_aA, w_aB, w_oA, w_oB;
  logic [3:0]  w_r1, w_r2, w_o1, w_o2, w_ctl, w_octl;
  logic        w_wb, w_owb;
  logic [1:0]  w_occ;

  id_ex_pipe_stage u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluA_in(aA), .aluB_in(aB),
    .gp_rdata1_address_in(r1),
    .gp_rdata2_address_in(r2),
    .alu_ctrl_in(ctl), .gp_reg_wb_in(wb),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluA_out(oA), .aluB_out(oB),
    .gp_rdata1_address_out(o1),
    .gp_rdata2_address_out(o2),
    .alu_ctrl_out(octl), .gp_reg_wb_out(owb),
    .occupancy(occ)
  );

  id_ex_pipe_stage #(.SKID(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(z_flush),
    .in_valid(z_iv), .in_ready(z_ir),
    .aluA_in(z_aA), .aluB_in(z_aB),
    .gp_rdata1_address_in(z_r1),
    .gp_rdata2_address_in(z_r2),
    .alu_ctrl_in(z_ctl), .gp_reg_wb_in(z_wb),
    .out_valid(z_ov), .out_ready(z_or),
    .aluA_out(z_oA), .aluB_out(z_oB),
    .gp_rdata1_address_out(z_o1),
    .gp_rdata2_address_out(z_o2),
    .alu_ctrl_out(z_octl), .gp_reg_wb_out(z_owb),
    .occupancy(z_occ)
  );

  id_ex_pipe_stage #(
    .DATA_W(16), .ADDR_W(4), .CTRL_W(4)
  ) u_dutw (
    .clk(clk), .reset(reset), .flush(w_flush),
    .in_valid(w_iv), .in_ready(w_ir),
    .aluA_in(w_aA), .aluB_in(w_aB),
    .gp_rdata1_address_in(w_r1),
    .gp_rdata2_address_in(w_r2),
    .alu_ctrl_in(w_ctl), .gp_reg_wb_in(w_wb),
    .out_valid(w_ov), .out_ready(w_or),
    .aluA_out(w_oA), .aluB_out(w_oB),
    .gp_rdata1_address_out(w_o1),
    .gp_rdata2_address_out(w_o2),
    .alu_ctrl_out(w_octl), .gp_reg_wb_out(w_owb),
    .occupancy(w_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b0;
    flush = 0; in_valid = 0; out_ready = 0;
    aA = 0; aB = 0; r1 = 0; r2 = 0; ctl = 0; wb = 0;
    z_flush = 0; z_iv = 0; z_or = 0;
    z_aA = 0; z_aB = 0; z_r1 = 0; z_r2 = 0;
    z_ctl = 0; z_wb = 0;
    w_flush = 0; w_iv = 0; w_or = 0;
    w_aA = 0; w_aB = 0; w_r1 = 0; w_r2 = 0;
    w_ctl = 0; w_wb = 0;

    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_wb", owb, 0);
    chk("rst_oA", oA, 0);
    step(); step(); step();
    reset = 1'b1;
    chk("rel_ir", in_ready, 1);

    // first entry
    in_valid = 1; out_ready = 1;
    aA = 10'h155; aB = 10'h0AA; ctl = 3'b101; wb = 1;
    step();
    chk("s1_ov", out_valid, 1);
    chk("s1_oA", oA, 10'h155);
    chk("s1_oB", oB, 10'h0AA);
    chk("s1_ctl", octl, 5);
    chk("s1_wb", owb, 1);
    chk("s1_occ", occ, 1);

    // back-to-back stream
    aA = 1; step(); chk("st1", oA, 1);
    aA = 2; step(); chk("st2", oA, 2);
    aA = 3; step(); chk("st3", oA, 3);
    chk("st_occ", occ, 1);
    in_valid = 0;
    step();
    chk("st_end_ov", out_valid, 0);
    chk("st_end_wb", owb, 0);
    chk("st_end_occ", occ, 0);

    // backpressure with skid
    out_ready = 0; in_valid = 1; aA = 10'h001;
    step();
    chk("bp_occ1", occ, 1);
    chk("bp_ir1", in_ready, 1);
    aA = 10'h002;
    step();
    chk("bp_occ2", occ, 2);
    chk("bp_ir2", in_ready, 0);
    chk("bp_holdA", oA, 10'h001);
    in_valid = 0; aA = 10'h055;
    step();
    chk("bp_hold_occ", occ, 2);
    chk("bp_hold_oA", oA, 10'h001);
    out_ready = 1;
    step();
    chk("bp_B", oA, 10'h002);
    chk("bp_occB", occ, 1);
    chk("bp_irB", in_ready, 1);
    step();
    chk("bp_drained", out_valid, 0);
    chk("bp_occ0", occ, 0);

    // flush with both entries held
    out_ready = 0; in_valid = 1; aA = 10'h010;
    step();
    aA = 10'h020;
    step();
    chk("fl_occ2", occ, 2);
    flush = 1; aA = 10'h3FF;
    step();
    flush = 0; in_valid = 0;
    chk("fl_ov", out_valid, 0);
    chk("fl_wb", owb, 0);
    chk("fl_occ", occ, 0);
    out_ready = 1;
    step();
    chk("fl_post_ov", out_valid, 0);

    // flush discards an entry accepted the same cycle
    in_valid = 1; flush = 1; aA = 10'h3FF;
    chk("fl2_ir", in_ready, 1);
    step();
    flush = 0; in_valid = 0;
    chk("fl2_ov", out_valid, 0);
    chk("fl2_occ", occ, 0);
    step();
    chk("fl2_post_ov", out_valid, 0);

    // SKID=0: combinational in_ready
    z_or = 0; z_iv = 1; z_aA = 10'h007; z_wb = 1;
    #1;
    chk("z_ir_empty", z_ir, 1);
    step();
    chk("z_ov", z_ov, 1);
    chk("z_oA7", z_oA, 10'h007);
    chk("z_ir_full", z_ir, 0);
    chk("z_occ1", z_occ, 1);
    z_aA = 10'h008;
    step();
    chk("z_hold", z_oA, 10'h007);
    chk("z_occ_max", z_occ, 1);
    z_or = 1;
    #1;
    chk("z_ir_or", z_ir, 1);
    step();
    chk("z_oA8", z_oA, 10'h008);
    chk("z_occ_pass", z_occ, 1);
    z_iv = 0;
    step();
    chk("z_empty", z_ov, 0);
    chk("z_wb0", z_owb, 0);

    // wide instance
    w_iv = 1; w_or = 1;
    w_aA = 16'hBEEF; w_r2 = 4'hC; w_ctl = 4'h9;
    step();
    w_iv = 0;
    chk("w_oA", w_oA, 16'hBEEF);
    chk("w_o2", w_o2, 4'hC);
    chk("w_ctl", w_octl, 4'h9);
    chk("w_ov", w_ov, 1);

    // async reset between edges
    in_valid = 1; out_ready = 1; aA = 10'h0AB; wb = 1;
    step();
    in_valid = 0; out_ready = 0;
    chk("ar_occ1", occ, 1);
    chk("ar_wb1", owb, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_ov", out_valid, 0);
    chk("ar_wb", owb, 0);
    chk("ar_occ", occ, 0);
    chk("ar_ir", in_ready, 1);
    step();
    reset = 1'b1;
    step();
    chk("ar_post_ov", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
